// File: rtl/voice_allocator_if.sv
// Key-vector input and per-voice outputs between the keyboard decoder and the voice allocator.
// The allocator takes the slave side; the keyboard/oscillator side takes the master side.
interface voice_allocator_if #(
  parameter int NUM_KEYS   = 88,
  parameter int NUM_VOICES = 12,
  parameter int KEY_W      = 7
);
  logic [NUM_KEYS-1:0]         keys;
  logic [NUM_VOICES-1:0]       voice_active;
  logic [NUM_VOICES*KEY_W-1:0] voice_key;
  logic [NUM_VOICES-1:0]       voice_start;
  logic                        key_pressed;
  logic                        pass_done;

  modport master (
    output keys,
    input  voice_active, voice_key, voice_start, key_pressed, pass_done
  );

  modport slave (
    input  keys,
    output voice_active, voice_key, voice_start, key_pressed, pass_done
  );
endinterface

// File: rtl/voice_allocator.sv
// Binds pressed keys to a pool of tone-generator voices, scanning one key per clock.
// Optional macro VOICE_STEAL_EN: a press with no free voice steals the oldest voice.
module voice_allocator #(
  parameter int NUM_KEYS   = 88,
  parameter int NUM_VOICES = 12,
  parameter int KEY_W      = 7,
  parameter int AGE_W      = 8
) (
  input  logic             iCLK_18_4,
  input  logic             iRST_N,
  voice_allocator_if.slave bus
);
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic {S_LATCH, S_SCAN} state_t;

  state_t                r_state;
  logic [KEY_W-1:0]      r_idx;
  logic [NUM_KEYS-1:0]   r_snap;
  logic [AGE_W-1:0]      r_age [NUM_VOICES];
  logic [KEY_W-1:0]      r_key [NUM_VOICES];
  logic [NUM_VOICES-1:0] r_active;
  logic [NUM_VOICES-1:0] r_start;
  logic                  r_pressed;
  logic                  r_done;

  logic                  w_hit;
  logic [VW-1:0]         w_hit_v;
  logic                  w_free;
  logic [VW-1:0]         w_free_v;
  logic                  w_blocked;
  logic                  w_last;

  // Voice keys are unique, so at most one hit; the descending loop leaves the lowest free voice.
  always_comb begin
    w_hit    = 1'b0;
    w_hit_v  = '0;
    w_free   = 1'b0;
    w_free_v = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (r_active[v] && (r_key[v] == r_idx)) begin
        w_hit   = 1'b1;
        w_hit_v = VW'(v);
      end
      if (!r_active[v]) begin
        w_free   = 1'b1;
        w_free_v = VW'(v);
      end
    end
  end

  assign w_last = (r_idx == KEY_W'(NUM_KEYS - 1));

`ifdef VOICE_STEAL_EN
  logic [NUM_KEYS-1:0] r_stolen;
  logic [VW-1:0]       w_old_v;
  logic [AGE_W-1:0]    w_old_age;

  // Strictly-greater compare keeps the lowest index on age ties.
  always_comb begin
    w_old_v   = '0;
    w_old_age = r_age[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (r_age[v] > w_old_age) begin
        w_old_v   = VW'(v);
        w_old_age = r_age[v];
      end
    end
  end

  assign w_blocked = r_stolen[r_idx];
`else
  assign w_blocked = 1'b0;
`endif

  always_ff @(posedge iCLK_18_4) begin
    if (!iRST_N) begin
      r_state   <= S_LATCH;
      r_idx     <= '0;
      r_snap    <= '0;
      r_active  <= '0;
      r_start   <= '0;
      r_pressed <= 1'b0;
      r_done    <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_age[v] <= '0;
        r_key[v] <= '0;
      end
`ifdef VOICE_STEAL_EN
      r_stolen  <= '0;
`endif
    end else begin
      r_start   <= '0;
      r_done    <= 1'b0;
      r_pressed <= |r_active;
      case (r_state)
        S_LATCH: begin
          r_snap <= bus.keys;
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (r_active[v] && (r_age[v] != {AGE_W{1'b1}}))
              r_age[v] <= r_age[v] + 1'b1;
          end
          r_idx   <= '0;
          r_state <= S_SCAN;
        end
        S_SCAN: begin
          if (!r_snap[r_idx]) begin
            if (w_hit)
              r_active[w_hit_v] <= 1'b0;
`ifdef VOICE_STEAL_EN
            r_stolen[r_idx] <= 1'b0;
`endif
          end else if (!w_hit && !w_blocked) begin
            if (w_free) begin
              r_active[w_free_v] <= 1'b1;
              r_key[w_free_v]    <= r_idx;
              r_age[w_free_v]    <= '0;
              r_start[w_free_v]  <= 1'b1;
            end
`ifdef VOICE_STEAL_EN
            else begin
              r_key[w_old_v]           <= r_idx;
              r_age[w_old_v]           <= '0;
              r_start[w_old_v]         <= 1'b1;
              r_stolen[r_key[w_old_v]] <= 1'b1;
            end
`endif
          end
          if (w_last) begin
            r_done  <= 1'b1;
            r_state <= S_LATCH;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= S_LATCH;
      endcase
    end
  end

  assign bus.voice_active = r_active;
  assign bus.voice_start  = r_start;
  assign bus.key_pressed  = r_pressed;
  assign bus.pass_done    = r_done;

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_key_out
    assign bus.voice_key[gi*KEY_W +: KEY_W] = r_key[gi];
  end
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: reset, single press, table of key patterns, mid-scan reset.
// Build with +define+VOICE_STEAL_EN to exercise the voice-stealing variant.
module tb_voice_allocator;
  localparam int NK = 88;
  localparam int NV = 12;
  localparam int KW = 7;
  localparam int PASS = NK + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  voice_allocator_if #(.NUM_KEYS(NK), .NUM_VOICES(NV), .KEY_W(KW)) bus ();

  voice_allocator #(.NUM_KEYS(NK), .NUM_VOICES(NV), .KEY_W(KW), .AGE_W(8)) dut (
    .iCLK_18_4 (clk),
    .iRST_N    (rst_n),
    .bus       (bus)
  );

  typedef struct {
    logic [NK-1:0]    keys;
    logic [NV-1:0]    exp_active;
    logic [NV-1:0]    exp_start;
    logic [NV*KW-1:0] exp_vk;
  } vec_t;

  vec_t tbl [10];
  int   n_vec;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [NV-1:0] start_seen;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [NK-1:0] range_keys(input int lo, input int hi);
    logic [NK-1:0] k = '0;
    for (int i = lo; i <= hi; i++) k[i] = 1'b1;
    return k;
  endfunction

  function automatic logic [NV*KW-1:0] vk12(input int k0, k1, k2, k3, k4, k5,
                                            input int k6, k7, k8, k9, k10, k11);
    int a [NV];
    logic [NV*KW-1:0] r;
    a[0] = k0; a[1] = k1; a[2] = k2; a[3] = k3; a[4] = k4; a[5] = k5;
    a[6] = k6; a[7] = k7; a[8] = k8; a[9] = k9; a[10] = k10; a[11] = k11;
    for (int v = 0; v < NV; v++) r[v*KW +: KW] = KW'(a[v]);
    return r;
  endfunction

  // Runs until n pass_done pulses are seen, collecting voice_start pulses on the way.
  task automatic run_passes(input int n, input string name);
    int cnt = 0;
    int budget = n * PASS + 10;
    while (cnt < n && budget > 0) begin
      @(negedge clk);
      start_seen |= bus.voice_start;
      if (bus.pass_done) cnt++;
      budget--;
    end
    if (cnt < n) begin
      n_checks++;
      $display("FAIL %s_timeout: got %0d passes expected %0d", name, cnt, n);
    end
  endtask

  initial begin
    logic [NK-1:0] tk;
    logic [NV*KW-1:0] vk_lo;
    int waited;

    // Table: applied in order, state carries across rows.
    n_vec = 0;
    tbl[n_vec++] = '{'0, 12'h000, 12'h000, vk12(39,0,0,0,0,0,0,0,0,0,0,0)};
    tk = '0; tk[10] = 1'b1; tk[20] = 1'b1;
    tbl[n_vec++] = '{tk, 12'h003, 12'h003, vk12(10,20,0,0,0,0,0,0,0,0,0,0)};
    tk = '0; tk[20] = 1'b1;
    tbl[n_vec++] = '{tk, 12'h002, 12'h000, vk12(10,20,0,0,0,0,0,0,0,0,0,0)};
    tk[50] = 1'b1;
    tbl[n_vec++] = '{tk, 12'h003, 12'h001, vk12(50,20,0,0,0,0,0,0,0,0,0,0)};
    tbl[n_vec++] = '{'0, 12'h000, 12'h000, vk12(50,20,0,0,0,0,0,0,0,0,0,0)};
`ifdef VOICE_STEAL_EN
    tbl[n_vec++] = '{range_keys(0,12), 12'hfff, 12'hfff, vk12(12,1,2,3,4,5,6,7,8,9,10,11)};
    tbl[n_vec++] = '{range_keys(1,11), 12'hffe, 12'h000, vk12(12,1,2,3,4,5,6,7,8,9,10,11)};
    tbl[n_vec++] = '{range_keys(0,11), 12'hfff, 12'h001, vk12(0,1,2,3,4,5,6,7,8,9,10,11)};
    tbl[n_vec++] = '{range_keys(0,12), 12'hfff, 12'h002, vk12(0,12,2,3,4,5,6,7,8,9,10,11)};
    tbl[n_vec++] = '{'0, 12'h000, 12'h000, vk12(0,12,2,3,4,5,6,7,8,9,10,11)};
`else
    tbl[n_vec++] = '{range_keys(0,12), 12'hfff, 12'hfff, vk12(0,1,2,3,4,5,6,7,8,9,10,11)};
    tk = range_keys(0,12); tk[5] = 1'b0;
    tbl[n_vec++] = '{tk, 12'hfff, 12'h020, vk12(0,1,2,3,4,12,6,7,8,9,10,11)};
    tbl[n_vec++] = '{'0, 12'h000, 12'h000, vk12(0,1,2,3,4,12,6,7,8,9,10,11)};
`endif

    // Reset with every key held.
    bus.keys = '1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_active", bus.voice_active, 0);
    check("rst_key", bus.voice_key, 0);
    check("rst_start", bus.voice_start, 0);
    check("rst_pressed", bus.key_pressed, 0);
    check("rst_done", bus.pass_done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel1_start", bus.voice_start, 0);
    @(negedge clk);
    check("rel2_start", bus.voice_start, 12'h001);
    check("rel2_active", bus.voice_active, 12'h001);
    check("rel2_pressed", bus.key_pressed, 0);
    run_passes(1, "allheld");
    check("allheld_active", bus.voice_active, 12'hfff);
    check("allheld_key", bus.voice_key, vk12(0,1,2,3,4,5,6,7,8,9,10,11));

    // Clear state, then a single press of key 39.
    bus.keys = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst2_key", bus.voice_key, 0);
    rst_n = 1'b1;
    bus.keys[39] = 1'b1;
    waited = 0;
    while (bus.voice_start == 0 && waited < 2 * PASS) begin
      @(negedge clk);
      waited++;
    end
    check("press_start", bus.voice_start, 12'h001);
    check("press_active", bus.voice_active, 12'h001);
    check("press_key0", bus.voice_key[0 +: KW], 39);
    check("press_pressed_lag", bus.key_pressed, 0);
    @(negedge clk);
    check("press_start_1cyc", bus.voice_start, 0);
    check("press_pressed", bus.key_pressed, 1);

    for (int i = 0; i < n_vec; i++) begin
      bus.keys = tbl[i].keys;
      start_seen = '0;
      run_passes(3, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_active", i), bus.voice_active, tbl[i].exp_active);
      check($sformatf("vec%0d_key", i), bus.voice_key, tbl[i].exp_vk);
      check($sformatf("vec%0d_start", i), start_seen, tbl[i].exp_start);
      check($sformatf("vec%0d_pressed", i), bus.key_pressed, |tbl[i].exp_active);
      $display("vec%0d keys=%0h active=%03h start=%03h", i, tbl[i].keys, bus.voice_active, start_seen);
    end

    // Mid-scan reset at idx 40 with three voices active.
    tk = '0; tk[3] = 1'b1; tk[4] = 1'b1; tk[5] = 1'b1;
    bus.keys = tk;
    run_passes(3, "mid_setup");
    check("mid_setup_active", bus.voice_active, 12'h007);
    @(negedge clk);
    repeat (41) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_active", bus.voice_active, 0);
    check("mid_rst_key", bus.voice_key, 0);
    check("mid_rst_pressed", bus.key_pressed, 0);
    start_seen = '0;
    run_passes(1, "mid_rebind");
    vk_lo = '0;
    vk_lo[0 +: 3*KW] = {7'd5, 7'd4, 7'd3};
    check("mid_rebind_active", bus.voice_active, 12'h007);
    check("mid_rebind_key", bus.voice_key, vk_lo);
    check("mid_rebind_start", start_seen, 12'h007);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
